// File: rtl/mul_i8_i8_i8.sv
// 8x8 -> 8 bit truncating multiplier built as a shift-and-add array.
// Define MUL_I8_OUTREG_EN to register y (1-cycle latency, sync reset to 0).
module mul_i8_i8_i8 (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  logic [7:0][7:0] pp;
  logic [7:0]      prod;

  // Shifted-out bits only affect product bits >= 8, so each term is kept at 8 bits.
  genvar i;
  for (i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = b[i] ? 8'(a << i) : 8'h00;
  end

  always_comb begin
    prod = 8'h00;
    for (int k = 0; k < 8; k++) prod = prod + pp[k];
  end

`ifdef MUL_I8_OUTREG_EN
  logic [7:0] y_d, y_q;

  always_comb begin
    y_d = prod;
    if (reset) y_d = 8'h00;
  end

  always_ff @(posedge clock) y_q <= y_d;

  assign y = y_q;
`else
  // Purely combinational: clock and reset intentionally have no effect.
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset;
  assign y = prod;
`endif

endmodule

// File: tb/tb_mul_i8_i8_i8.sv
// Self-checking bench for mul_i8_i8_i8; checks both builds via MUL_I8_OUTREG_EN.
module tb_mul_i8_i8_i8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic [7:0] y;

  int n_asrt = 0;
  int n_fail = 0;

  mul_i8_i8_i8 dut (.clock(clock), .reset(reset), .a(a), .b(b), .y(y));

  always #5 clock = ~clock;

  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] z);
    int p;
    p = int'(x) * int'(z);
    return 8'(p % 256);
  endfunction

  task automatic chk(input string tag, input logic [7:0] exp);
    n_asrt++;
    assert (y === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, y, exp);
    end
  endtask

  // Apply operands just after an edge, then sample 1 time unit after the next edge.
  // Inputs are held across that edge, so the same expectation fits both builds.
  task automatic step(input logic [7:0] xa, input logic [7:0] xb);
    a = xa;
    b = xb;
    @(posedge clock);
    #1;
  endtask

  logic [7:0] da [8] = '{8'd0,   8'd200, 8'd1,   8'd255, 8'd16, 8'd15, 8'hF6, 8'd1};
  logic [7:0] db [8] = '{8'd200, 8'd0,   8'd173, 8'd255, 8'd16, 8'd17, 8'h05, 8'd91};
  logic [7:0] de [8] = '{8'd0,   8'd0,   8'd173, 8'd1,   8'd0,  8'd255, 8'hCE, 8'd91};

  initial begin
    logic [7:0] ra, rb;
    int sp;

    // Reset held for 16 cycles with a=9, b=3.
    a = 8'd9;
    b = 8'd3;
    reset = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clock);
      #1;
    end
`ifdef MUL_I8_OUTREG_EN
    chk("reset_value", 8'h00);
`else
    chk("during_reset", 8'd27);
`endif
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("after_release", 8'h1B);

    // Directed boundary and wrap cases.
    for (int k = 0; k < 8; k++) begin
      step(da[k], db[k]);
      chk($sformatf("directed_%0d", k), de[k]);
    end

    // Signed interpretation gives the same low byte.
    sp = (-10) * 5;
    step(8'hF6, 8'h05);
    chk("signed_neg10x5", 8'(sp));

`ifndef MUL_I8_OUTREG_EN
    // Combinational path follows inputs within the cycle, and ignores reset.
    a = 8'd7;
    b = 8'd11;
    #1;
    chk("comb_same_cycle", 8'd77);
    reset = 1'b1;
    #1;
    chk("comb_reset_ignored", 8'd77);
    reset = 1'b0;
`endif

    // Random stream, one pair per cycle.
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      step(ra, rb);
      chk("random", ref_mul(ra, rb));
    end

`ifdef MUL_I8_OUTREG_EN
    // Mid-stream reset discards the in-flight product.
    step(8'd9, 8'd3);
    chk("pre_reset", 8'd27);
    a = 8'd100;
    b = 8'd3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_reset", 8'h00);
    a = 8'd9;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_reset", 8'd27);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
